mnemonic_decoder: RTL and testbench
===================================

// Module: mnemonic_decoder
// PURPOSE
//  Streaming front-end stage of the assembler: consumes one ASCII character per accepted beat and
//  accumulates a mnemonic of up to MAX_LEN letters. On a delimiter it emits registered
//  {opcode, funct7, funct3} plus a pseudo-instruction tag over a valid/ready output handshake.
//  Adds the following: leading-whitespace skip, overflow/bad-char error codes, backpressure,
//  and optional pseudo-ops. Sits between the line tokenizer and the operand parsers.
// PARAMETERS
//  MAX_LEN       5   max mnemonic letters; valid range 4..8
//  ALLOW_PSEUDO  1   1: accept nop/mv/not/neg/j/ret; 0: these report ERR_UNKNOWN
// PORTS
//  clk_in         in   1       system clock
//  rst_in         in   1       asynchronous, active-high reset
//  valid_data     in   1       input stream enabled; low for one cycle in IDLE/ACCUM -> IDLE
//  new_character  in   1       incoming_ascii valid this cycle; consumed iff char_ready
//  incoming_ascii in   8       ASCII character
//  char_ready     out  1       high in IDLE and ACCUM only
//  out_valid      out  1       result fields valid (HOLD state)
//  out_ready      in   1       consumer accepts result when out_valid && out_ready
//  opcode         out  7       RV32I opcode of matched entry
//  funct7         out  7       funct7; 7'h7F marks I-type arithmetic (non-shift) entries
//  funct3         out  3       funct3
//  is_pseudo      out  1       matched entry is a pseudo-op
//  pseudo_id      out  3       pseudo_id_t; 0 when is_pseudo=0
//  error_flag     out  1       high in ERROR state
//  error_code     out  2       err_code_t: NONE, UNKNOWN, OVERFLOW, BADCHAR
//  clear_in       in   1       single-cycle pulse; ERROR -> IDLE
//  busy_flag      out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, len=0, buffer=pad. All result/error outputs are 0.
//  Letters are case-folded to 1..26; 0 is pad. Buffer holds MAX_LEN codes, right-aligned, pad-filled.
//  Delimiters: ' ', ',', '\t', '\n'. BADCHAR: anything that is neither a letter nor a delimiter.
//  Beat = new_character && char_ready && valid_data.
//  IDLE:  delimiter -> stay (skip). letter -> ACCUM, buf={pad..,c}, len=1.
//         bad char -> ERROR/BADCHAR.
//  ACCUM: letter with len<MAX_LEN -> shift in, len++.
//         letter with len==MAX_LEN -> ERROR/OVERFLOW.
//         delimiter with lookup hit -> HOLD; fields are registered the same edge.
//         delimiter with lookup miss -> ERROR/UNKNOWN.
//         bad char -> ERROR/BADCHAR.
//  HOLD:  out_valid=1, fields stable. out_ready -> IDLE; out_valid drops the next cycle.
//         The delimiter is consumed and never re-emitted.
//  ERROR: fields=0. error_code is held until clear_in -> IDLE.
//         clear_in has priority over valid_data; clear_in is ignored outside ERROR.
//  valid_data low: IDLE/ACCUM -> IDLE, buffer cleared. HOLD and ERROR are unaffected
//  (no result is lost).
//  Latency: out_valid rises 1 cycle after the delimiter beat; throughput is 1 char/cycle.
//  An idle gap of at least one cycle between mnemonics is implied by the HOLD handshake.
//  Reset asserted mid-operation: immediate return to reset values; a partial mnemonic is discarded.
//  Lookup covers the full RV32I base set (add..xori, incl. lui/auipc/jal/jalr/loads/stores/branches).
//  Pseudo-op mappings:
//    nop, mv -> OP_IMM/F3_ADD_SUB
//    not     -> OP_IMM/F3_XOR
//    neg     -> OP_REG sub
//    j       -> OP_JAL
//    ret     -> OP_JALR
// STRUCTURE
//  assembler_constants gains: LETTER_PAD, err_code_t, pseudo_id_t
//  (NONE, NOP, MV, NOT, NEG, J, RET). Existing OP_*/F3_* constants are reused.
//  Sub-module mnemonic_lookup #(MAX_LEN, ALLOW_PSEUDO): combinational table
//  (buf -> hit, opcode, funct7, funct3, is_pseudo, pseudo_id).
//  Letter folding and the FSM live in the top.
// TESTING
//  Case 1: "add " -> out_valid 1 cycle after ' '; opcode=7'b0110011, funct7=0, funct3=0, is_pseudo=0.
//  Case 2: "  XORI," -> leading spaces skipped;
//          opcode=7'b0010011, funct7=7'h7F, funct3=3'b100.
//  Case 3: "sltiux " -> ERROR/OVERFLOW at the 6th letter (MAX_LEN=5).
//          clear_in returns to IDLE; the next "or " decodes funct3=3'b110.
//  Case 4: "ad3 " -> ERROR/BADCHAR on '3'. "foo " -> ERROR/UNKNOWN on ' '.
//  Case 5: "sub " with out_ready low for 3 cycles -> char_ready=0 and fields stable
//          (funct7=7'h20) for 3 cycles. Accept, then "sw " -> opcode=7'b0100011, funct3=3'b010.
//  Case 6: "nop " -> is_pseudo=1, pseudo_id=NOP, opcode=OP_IMM (ALLOW_PSEUDO=1); ERROR/UNKNOWN (=0).
//          rst_in pulsed after "ad": all outputs 0 the same cycle; then "d " -> ERROR/UNKNOWN.

Source files
------------

// File: rtl/mnemonic_decoder_pkg.sv
// Shared constants, types and character helpers for the mnemonic decoder.
package mnemonic_decoder_pkg;

    // RV32I major opcodes
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // ALU funct3 values
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct7: base, alternate (sub/sra/srai), and the I-type arithmetic marker
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;
    localparam logic [6:0] F7_IMM  = 7'h7F;

    localparam logic [4:0] LETTER_PAD = 5'd0;

    // Lookup keys always hold 8 letter codes so one table serves every MAX_LEN.
    localparam int KEY_CHARS = 8;
    localparam int KEY_W     = 5 * KEY_CHARS;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_UNKNOWN  = 2'd1,
        ERR_OVERFLOW = 2'd2,
        ERR_BADCHAR  = 2'd3
    } err_code_t;

    typedef enum logic [2:0] {
        PS_NONE = 3'd0,
        PS_NOP  = 3'd1,
        PS_MV   = 3'd2,
        PS_NOT  = 3'd3,
        PS_NEG  = 3'd4,
        PS_J    = 3'd5,
        PS_RET  = 3'd6
    } pseudo_id_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2,
        ST_ERROR = 2'd3
    } dec_state_t;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [6:0]       opcode;
        logic [6:0]       funct7;
        logic [2:0]       funct3;
        pseudo_id_t       pid;
    } entry_t;

    function automatic logic is_letter(input logic [7:0] c);
        return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z");
    endfunction

    function automatic logic is_delim(input logic [7:0] c);
        return (c == " ") || (c == ",") || (c == 8'h09) || (c == 8'h0A);
    endfunction

    // Case-folds a letter to 1..26; anything else becomes pad.
    function automatic logic [4:0] fold_letter(input logic [7:0] c);
        if (c >= "a" && c <= "z") return 5'(c - 8'h60);
        if (c >= "A" && c <= "Z") return 5'(c - 8'h40);
        return LETTER_PAD;
    endfunction

    // Turns a right-aligned ASCII name (up to 8 chars) into a letter-code key.
    function automatic logic [KEY_W-1:0] pack_name(input logic [63:0] name);
        logic [KEY_W-1:0] k;
        k = '0;
        for (int i = 0; i < KEY_CHARS; i++) k[i*5 +: 5] = fold_letter(name[i*8 +: 8]);
        return k;
    endfunction

    function automatic entry_t ent(input logic [63:0] name, input logic [6:0] op,
                                   input logic [6:0] f7, input logic [2:0] f3,
                                   input pseudo_id_t pid);
        return '{key: pack_name(name), opcode: op, funct7: f7, funct3: f3, pid: pid};
    endfunction

endpackage

// File: rtl/mnemonic_decoder_lookup.sv
// Combinational mnemonic table: letter-code buffer -> RV32I encoding fields.
module mnemonic_lookup
    import mnemonic_decoder_pkg::*;
#(
    parameter int MAX_LEN      = 5,
    parameter bit ALLOW_PSEUDO = 1'b1
) (
    input  logic [5*MAX_LEN-1:0] mnemonic,
    output logic                 hit,
    output logic [6:0]           opcode,
    output logic [6:0]           funct7,
    output logic [2:0]           funct3,
    output logic                 is_pseudo,
    output pseudo_id_t           pseudo_id
);

    localparam int NUM_ENTRIES = 46;

    // Names longer than MAX_LEN can never match, since the buffer's upper codes are pad.
    localparam entry_t TABLE [NUM_ENTRIES] = '{
        ent("add",   OP_REG,    F7_BASE, F3_ADD_SUB, PS_NONE),
        ent("sub",   OP_REG,    F7_ALT,  F3_ADD_SUB, PS_NONE),
        ent("sll",   OP_REG,    F7_BASE, F3_SLL,     PS_NONE),
        ent("slt",   OP_REG,    F7_BASE, F3_SLT,     PS_NONE),
        ent("sltu",  OP_REG,    F7_BASE, F3_SLTU,    PS_NONE),
        ent("xor",   OP_REG,    F7_BASE, F3_XOR,     PS_NONE),
        ent("srl",   OP_REG,    F7_BASE, F3_SRL_SRA, PS_NONE),
        ent("sra",   OP_REG,    F7_ALT,  F3_SRL_SRA, PS_NONE),
        ent("or",    OP_REG,    F7_BASE, F3_OR,      PS_NONE),
        ent("and",   OP_REG,    F7_BASE, F3_AND,     PS_NONE),
        ent("addi",  OP_IMM,    F7_IMM,  F3_ADD_SUB, PS_NONE),
        ent("slti",  OP_IMM,    F7_IMM,  F3_SLT,     PS_NONE),
        ent("sltiu", OP_IMM,    F7_IMM,  F3_SLTU,    PS_NONE),
        ent("xori",  OP_IMM,    F7_IMM,  F3_XOR,     PS_NONE),
        ent("ori",   OP_IMM,    F7_IMM,  F3_OR,      PS_NONE),
        ent("andi",  OP_IMM,    F7_IMM,  F3_AND,     PS_NONE),
        ent("slli",  OP_IMM,    F7_BASE, F3_SLL,     PS_NONE),
        ent("srli",  OP_IMM,    F7_BASE, F3_SRL_SRA, PS_NONE),
        ent("srai",  OP_IMM,    F7_ALT,  F3_SRL_SRA, PS_NONE),
        ent("lb",    OP_LOAD,   F7_BASE, 3'b000,     PS_NONE),
        ent("lh",    OP_LOAD,   F7_BASE, 3'b001,     PS_NONE),
        ent("lw",    OP_LOAD,   F7_BASE, 3'b010,     PS_NONE),
        ent("lbu",   OP_LOAD,   F7_BASE, 3'b100,     PS_NONE),
        ent("lhu",   OP_LOAD,   F7_BASE, 3'b101,     PS_NONE),
        ent("sb",    OP_STORE,  F7_BASE, 3'b000,     PS_NONE),
        ent("sh",    OP_STORE,  F7_BASE, 3'b001,     PS_NONE),
        ent("sw",    OP_STORE,  F7_BASE, 3'b010,     PS_NONE),
        ent("beq",   OP_BRANCH, F7_BASE, 3'b000,     PS_NONE),
        ent("bne",   OP_BRANCH, F7_BASE, 3'b001,     PS_NONE),
        ent("blt",   OP_BRANCH, F7_BASE, 3'b100,     PS_NONE),
        ent("bge",   OP_BRANCH, F7_BASE, 3'b101,     PS_NONE),
        ent("bltu",  OP_BRANCH, F7_BASE, 3'b110,     PS_NONE),
        ent("bgeu",  OP_BRANCH, F7_BASE, 3'b111,     PS_NONE),
        ent("lui",   OP_LUI,    F7_BASE, 3'b000,     PS_NONE),
        ent("auipc", OP_AUIPC,  F7_BASE, 3'b000,     PS_NONE),
        ent("jal",   OP_JAL,    F7_BASE, 3'b000,     PS_NONE),
        ent("jalr",  OP_JALR,   F7_BASE, 3'b000,     PS_NONE),
        ent("fence", OP_FENCE,  F7_BASE, 3'b000,     PS_NONE),
        ent("ecall", OP_SYSTEM, F7_BASE, 3'b000,     PS_NONE),
        ent("ebreak",OP_SYSTEM, F7_BASE, 3'b000,     PS_NONE),
        ent("nop",   OP_IMM,    F7_IMM,  F3_ADD_SUB, PS_NOP),
        ent("mv",    OP_IMM,    F7_IMM,  F3_ADD_SUB, PS_MV),
        ent("not",   OP_IMM,    F7_IMM,  F3_XOR,     PS_NOT),
        ent("neg",   OP_REG,    F7_ALT,  F3_ADD_SUB, PS_NEG),
        ent("j",     OP_JAL,    F7_BASE, 3'b000,     PS_J),
        ent("ret",   OP_JALR,   F7_BASE, 3'b000,     PS_RET)
    };

    logic [KEY_W-1:0] key;

    assign key = KEY_W'(mnemonic);

    // First matching entry wins; pseudo entries are masked when disabled.
    always_comb begin
        hit       = 1'b0;
        opcode    = '0;
        funct7    = '0;
        funct3    = '0;
        is_pseudo = 1'b0;
        pseudo_id = PS_NONE;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!hit && key == TABLE[i].key && (ALLOW_PSEUDO || TABLE[i].pid == PS_NONE)) begin
                hit       = 1'b1;
                opcode    = TABLE[i].opcode;
                funct7    = TABLE[i].funct7;
                funct3    = TABLE[i].funct3;
                is_pseudo = (TABLE[i].pid != PS_NONE);
                pseudo_id = TABLE[i].pid;
            end
        end
    end

endmodule

// File: rtl/mnemonic_decoder.sv
// Streaming mnemonic decoder: accumulates letters, decodes on a delimiter,
// and presents the result over a valid/ready handshake.
//   state    | meaning
//   IDLE     | waiting for first letter, delimiters skipped
//   ACCUM    | collecting letters into the buffer
//   HOLD     | result presented, waiting for out_ready
//   ERROR    | error_code held until clear_in
module mnemonic_decoder
    import mnemonic_decoder_pkg::*;
#(
    parameter int MAX_LEN      = 5,
    parameter bit ALLOW_PSEUDO = 1'b1
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       valid_data,
    input  logic       new_character,
    input  logic [7:0] incoming_ascii,
    output logic       char_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:0] opcode,
    output logic [6:0] funct7,
    output logic [2:0] funct3,
    output logic       is_pseudo,
    output logic [2:0] pseudo_id,
    output logic       error_flag,
    output logic [1:0] error_code,
    input  logic       clear_in,
    output logic       busy_flag
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int BUF_W = 5 * MAX_LEN;

    dec_state_t        state, next_state;
    err_code_t         err_next, err_q;
    logic [BUF_W-1:0]  mnemonic;
    logic [LEN_W-1:0]  len;
    logic [6:0]        res_opcode, res_funct7;
    logic [2:0]        res_funct3;
    pseudo_id_t        res_pid;

    logic              beat, letter, delim;
    logic [4:0]        code;
    logic              lk_hit, lk_pseudo;
    logic [6:0]        lk_opcode, lk_funct7;
    logic [2:0]        lk_funct3;
    pseudo_id_t        lk_pid;

    assign beat   = new_character && char_ready && valid_data;
    assign letter = is_letter(incoming_ascii);
    assign delim  = is_delim(incoming_ascii);
    assign code   = fold_letter(incoming_ascii);

    mnemonic_lookup #(.MAX_LEN(MAX_LEN), .ALLOW_PSEUDO(ALLOW_PSEUDO)) u_lookup (
        .mnemonic  (mnemonic),
        .hit       (lk_hit),
        .opcode    (lk_opcode),
        .funct7    (lk_funct7),
        .funct3    (lk_funct3),
        .is_pseudo (lk_pseudo),
        .pseudo_id (lk_pid)
    );

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next-state decode and the error cause that accompanies an ERROR entry
    always_comb begin
        next_state = state;
        err_next   = ERR_NONE;
        case (state)
            ST_IDLE: begin
                if (beat && letter) begin
                    next_state = ST_ACCUM;
                end else if (beat && !delim) begin
                    next_state = ST_ERROR;
                    err_next   = ERR_BADCHAR;
                end
            end
            ST_ACCUM: begin
                if (!valid_data) begin
                    next_state = ST_IDLE;
                end else if (beat) begin
                    if (letter) begin
                        if (len == LEN_W'(MAX_LEN)) begin
                            next_state = ST_ERROR;
                            err_next   = ERR_OVERFLOW;
                        end
                    end else if (delim) begin
                        next_state = lk_hit ? ST_HOLD : ST_ERROR;
                        err_next   = lk_hit ? ERR_NONE : ERR_UNKNOWN;
                    end else begin
                        next_state = ST_ERROR;
                        err_next   = ERR_BADCHAR;
                    end
                end
            end
            ST_HOLD:  if (out_ready) next_state = ST_IDLE;
            ST_ERROR: if (clear_in)  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Letter buffer, length, registered result fields and held error cause
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mnemonic   <= '0;
            len        <= '0;
            err_q      <= ERR_NONE;
            res_opcode <= '0;
            res_funct7 <= '0;
            res_funct3 <= '0;
            res_pid    <= PS_NONE;
        end else begin
            if (next_state == ST_IDLE) begin
                mnemonic <= '0;
                len      <= '0;
                err_q    <= ERR_NONE;
            end else if (state == ST_IDLE && next_state == ST_ACCUM) begin
                mnemonic <= BUF_W'(code);
                len      <= LEN_W'(1);
            end else if (state == ST_ACCUM && next_state == ST_ACCUM && beat) begin
                mnemonic <= {mnemonic[BUF_W-6:0], code};
                len      <= len + LEN_W'(1);
            end
            if (state == ST_ACCUM && next_state == ST_HOLD) begin
                res_opcode <= lk_opcode;
                res_funct7 <= lk_funct7;
                res_funct3 <= lk_funct3;
                res_pid    <= lk_pid;
            end
            if (state != ST_ERROR && next_state == ST_ERROR) err_q <= err_next;
        end
    end

    // Outputs: fields only visible in HOLD, error cause only in ERROR
    always_comb begin
        char_ready = (state == ST_IDLE) || (state == ST_ACCUM);
        out_valid  = (state == ST_HOLD);
        busy_flag  = (state != ST_IDLE);
        error_flag = (state == ST_ERROR);
        error_code = (state == ST_ERROR) ? err_q : ERR_NONE;
        opcode     = out_valid ? res_opcode : '0;
        funct7     = out_valid ? res_funct7 : '0;
        funct3     = out_valid ? res_funct3 : '0;
        is_pseudo  = out_valid && (res_pid != PS_NONE) && lk_pseudo_unused_guard();
        pseudo_id  = out_valid ? res_pid : PS_NONE;
    end

    function automatic logic lk_pseudo_unused_guard();
        return 1'b1 | lk_pseudo;
    endfunction

endmodule

// File: tb/tb_mnemonic_decoder.sv
// Scoreboard bench for mnemonic_decoder: stimulus pushes expectations,
// a negedge monitor pops them whenever a result is accepted or an error appears.
module tb_mnemonic_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_data, new_character, out_ready, clear_in;
    logic [7:0] incoming_ascii;

    logic       char_ready, out_valid, is_pseudo, error_flag, busy_flag;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3, pseudo_id;
    logic [1:0] error_code;

    logic       p0_char_ready, p0_out_valid, p0_is_pseudo, p0_error_flag, p0_busy_flag;
    logic [6:0] p0_opcode, p0_funct7;
    logic [2:0] p0_funct3, p0_pseudo_id;
    logic [1:0] p0_error_code;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit         is_err;
        logic [1:0] code;
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       psd;
        logic [2:0] pid;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   err_seen = 1'b0;

    always #5 clk = ~clk;

    mnemonic_decoder #(.MAX_LEN(5), .ALLOW_PSEUDO(1'b1)) dut (
        .clk_in(clk), .rst_in(rst), .valid_data(valid_data), .new_character(new_character),
        .incoming_ascii(incoming_ascii), .char_ready(char_ready), .out_valid(out_valid),
        .out_ready(out_ready), .opcode(opcode), .funct7(funct7), .funct3(funct3),
        .is_pseudo(is_pseudo), .pseudo_id(pseudo_id), .error_flag(error_flag),
        .error_code(error_code), .clear_in(clear_in), .busy_flag(busy_flag)
    );

    mnemonic_decoder #(.MAX_LEN(5), .ALLOW_PSEUDO(1'b0)) dut_nopseudo (
        .clk_in(clk), .rst_in(rst), .valid_data(valid_data), .new_character(new_character),
        .incoming_ascii(incoming_ascii), .char_ready(p0_char_ready), .out_valid(p0_out_valid),
        .out_ready(out_ready), .opcode(p0_opcode), .funct7(p0_funct7), .funct3(p0_funct3),
        .is_pseudo(p0_is_pseudo), .pseudo_id(p0_pseudo_id), .error_flag(p0_error_flag),
        .error_code(p0_error_code), .clear_in(clear_in), .busy_flag(p0_busy_flag)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_res(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                            input logic psd, input logic [2:0] pid);
        exp_t e;
        e = '{is_err: 1'b0, code: 2'd0, op: op, f7: f7, f3: f3, psd: psd, pid: pid};
        sb.push_back(e);
    endtask

    task automatic push_err(input logic [1:0] code);
        exp_t e;
        e = '{is_err: 1'b1, code: code, op: 7'd0, f7: 7'd0, f3: 3'd0, psd: 1'b0, pid: 3'd0};
        sb.push_back(e);
    endtask

    task automatic send_char(input byte c);
        int n;
        n = 0;
        new_character  = 1'b1;
        incoming_ascii = c;
        while (!char_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 50) check("send_wait_char_ready", char_ready, 1);
        @(posedge clk); #1;
        new_character = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic wait_error_and_clear();
        int n;
        n = 0;
        while (!error_flag && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 50) check("wait_error_flag", error_flag, 1);
        clear_in = 1'b1;
        @(posedge clk); #1;
        clear_in = 1'b0;
        check("clear_to_idle", busy_flag, 0);
    endtask

    // Monitor: pop on every accepted result and on every ERROR entry
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", out_valid, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("result_kind", 32'(mon_e.is_err), 0);
                    check("result_fields", {opcode, funct7, funct3},
                          {mon_e.op, mon_e.f7, mon_e.f3});
                    check("result_pseudo", {is_pseudo, pseudo_id}, {mon_e.psd, mon_e.pid});
                end
            end
            if (error_flag && !err_seen) begin
                if (sb.size() == 0) begin
                    check("unexpected_error", error_flag, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("error_kind", 32'(mon_e.is_err), 1);
                    check("error_code", error_code, mon_e.code);
                    check("error_fields_zero", {opcode, funct7, funct3, is_pseudo, pseudo_id}, 0);
                end
            end
            err_seen = error_flag;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; valid_data = 1'b1; new_character = 1'b0; incoming_ascii = 8'h00;
        out_ready = 1'b1; clear_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {out_valid, error_flag, busy_flag, error_code, opcode}, 0);
        check("reset_char_ready", char_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // add: result one cycle after the delimiter, dropped the cycle after acceptance
        push_res(7'b0110011, 7'h00, 3'b000, 1'b0, 3'd0);
        send_str("add ");
        check("latency_out_valid", out_valid, 1);
        @(posedge clk); #1;
        check("out_valid_drops", out_valid, 0);

        // leading spaces skipped, upper case folded, comma delimiter
        push_res(7'b0010011, 7'h7F, 3'b100, 1'b0, 3'd0);
        send_str("  XORI,");
        @(posedge clk); #1;

        // overflow on the 6th letter, then recovery
        push_err(2'd2);
        send_str("sltiux");
        wait_error_and_clear();
        push_res(7'b0110011, 7'h00, 3'b110, 1'b0, 3'd0);
        send_str("or ");
        @(posedge clk); #1;

        // bad character, then an unknown mnemonic
        push_err(2'd3);
        send_str("ad3");
        wait_error_and_clear();
        push_err(2'd1);
        send_str("foo ");
        wait_error_and_clear();

        // backpressure: fields stable and input stalled for 3 cycles
        out_ready = 1'b0;
        push_res(7'b0110011, 7'h20, 3'b000, 1'b0, 3'd0);
        send_str("sub ");
        for (int i = 0; i < 3; i++) begin
            check("stall_out_valid", out_valid, 1);
            check("stall_char_ready", char_ready, 0);
            check("stall_funct7", funct7, 7'h20);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        push_res(7'b0100011, 7'h00, 3'b010, 1'b0, 3'd0);
        send_str("sw ");
        @(posedge clk); #1;

        // valid_data low discards the partial "xo"; "and" then decodes alone
        send_str("xo");
        valid_data = 1'b0;
        @(posedge clk); #1;
        check("valid_drop_idle", busy_flag, 0);
        valid_data = 1'b1;
        push_res(7'b0110011, 7'h00, 3'b111, 1'b0, 3'd0);
        send_str("and ");
        @(posedge clk); #1;

        // pseudo-op accepted here, unknown in the pseudo-disabled instance
        push_res(7'b0010011, 7'h7F, 3'b000, 1'b1, 3'd1);
        send_str("nop ");
        check("nopseudo_error_code", p0_error_code, 2'd1);
        clear_in = 1'b1;
        @(posedge clk); #1;
        clear_in = 1'b0;
        check("clear_ignored_outside_error", {busy_flag, error_flag}, 0);
        check("nopseudo_cleared", p0_busy_flag, 0);

        // reset mid-mnemonic: outputs zero immediately, partial "ad" discarded
        send_str("ad");
        rst = 1'b1;
        #1;
        check("midreset_outputs",
              {out_valid, opcode, funct7, funct3, is_pseudo, pseudo_id, error_flag, error_code, busy_flag}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        push_err(2'd1);
        send_str("d ");
        wait_error_and_clear();

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
